cacheline_adaptor: RTL



---
 rtl/cacheline_adaptor_pkg.sv | 19 +
 rtl/cacheline_adaptor.sv | 107 ++++++++++
 2 files changed

// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and constants for the cache-line <-> burst-memory adaptor.
package cacheline_adaptor_pkg;

  localparam int unsigned LINE_W      = 256;
  localparam int unsigned BURST_W     = 64;
  localparam int unsigned BEATS       = LINE_W / BURST_W;
  localparam int unsigned OFFSET_BITS = 5;

  typedef logic [LINE_W-1:0]  line_t;
  typedef logic [BURST_W-1:0] burst_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts single-cycle cache-line requests into little-endian memory bursts
// of BEATS beats, and signals completion with a one-cycle resp_o pulse.
module cacheline_adaptor #(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);
  import cacheline_adaptor_pkg::*;

  localparam int unsigned BEATS_L = LINE_W / BURST_W;
  localparam int unsigned CNT_W   = (BEATS_L > 1) ? $clog2(BEATS_L) : 1;
  localparam int unsigned LINE_B  = LINE_W / 8;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_L - 1);

  adaptor_state_t      r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [LINE_W-1:0]   r_buf;
  logic [ADDR_W-1:0]   r_addr;

  logic [ADDR_W-1:0]   w_addr_aligned;
  logic                w_last;

  // Masking (rather than slicing) keeps every address bit in use.
  assign w_addr_aligned = address_i & ~ADDR_W'(LINE_B - 1);
  assign w_last         = (r_cnt == LAST_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (read_i) begin
            r_addr  <= w_addr_aligned;
            r_cnt   <= '0;
            r_state <= READ;
          end else if (write_i) begin
            r_addr  <= w_addr_aligned;
            r_buf   <= line_i;
            r_cnt   <= '0;
            r_state <= WRITE;
          end
        end
        READ: begin
          if (resp_i) begin
            for (int unsigned b = 0; b < BEATS_L; b++) begin
              if (r_cnt == CNT_W'(b)) r_buf[b*BURST_W +: BURST_W] <= burst_i;
            end
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) r_state <= DONE;
          end
        end
        WRITE: begin
          if (resp_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    burst_o = '0;
    if (r_state == WRITE) begin
      for (int unsigned b = 0; b < BEATS_L; b++) begin
        if (r_cnt == CNT_W'(b)) burst_o = r_buf[b*BURST_W +: BURST_W];
      end
    end
  end

  assign line_o    = r_buf;
  assign address_o = r_addr;
  assign read_o    = (r_state == READ);
  assign write_o   = (r_state == WRITE);
  assign resp_o    = (r_state == DONE);

`ifndef SYNTHESIS
  // Simultaneous requests resolve to a read; flag it so the arbiter bug is visible.
  always_ff @(posedge clk) begin
    if (!rst && r_state == IDLE)
      assert (!(read_i && write_i))
        else $warning("cacheline_adaptor: read_i and write_i both high, write ignored");
  end
`endif

endmodule
